tlk_bus_arbiter: RTL and testbench
==================================

// Module: tlk_bus_arbiter
// PURPOSE
//   Round-robin arbiter that shares one byte-wide output bus between N requesters.
//   Each requester sends bursts of bytes, one byte per beat.
//   A grant is held for a whole burst, which ends on a beat with last=1.
//   Sits in front of the shared tlk output datapath, so that datapath has exactly one
//   driver at a time instead of relying on resolved (multi-driven) nets.
// PARAMETERS
//   N          4   number of requesters (2..16)
//   DW         8   data width per beat (byte)
//   MAX_BEATS  16  burst length limit; used only when TLK_ARB_TIMEOUT_EN is defined
// PORTS
//   clk        in   1         clock; all logic on rising edge
//   rst        in   1         synchronous, active-high reset
//   req        in   N         req[i]: requester i has a valid beat this cycle
//   data       in   N x DW    data[i]: beat payload of requester i
//   last       in   N         last[i]: beat of requester i is the final beat of its burst
//   rdy        out  N         rdy[i]: beat of requester i accepted this cycle
//   gnt        out  N         one-hot owner of the bus; all zero when idle
//   bus_vld    out  1         shared bus carries a valid beat
//   bus_data   out  DW        shared bus payload
//   bus_last   out  1         shared bus beat is the final beat of the burst
//   bus_rdy    in   1         downstream accepts the beat
//   abort      out  1         one-cycle pulse: burst was cut at MAX_BEATS
// BEHAVIOUR
//   - Reset values: gnt=0, state=IDLE, ptr=N-1 (requester 0 wins the first arbitration),
//     beat_cnt=0, abort=0. Combinational outputs therefore reset to 0.
//   - FSM has two states, IDLE and BUSY.
//     - IDLE, req==0: stay in IDLE.
//     - IDLE, req!=0: pick the first set req[] at or after index (ptr+1) mod N, wrapping.
//       Register gnt=onehot(pick) and go to BUSY.
//     - BUSY: the owner is the index of gnt.
//       bus_vld = req[owner]; bus_data = data[owner]; bus_last = last[owner];
//       rdy = gnt & {N{bus_rdy}}.
//       A beat transfers when bus_vld & bus_rdy.
//     - BUSY, transfer with bus_last=1: next cycle gnt=0, ptr=owner, state=IDLE.
//   - In IDLE, bus_vld=0 and rdy=0 regardless of req.
//   - Latency: req to first possible transfer is 1 cycle.
//     There is a 1-cycle bubble between back-to-back bursts (an IDLE cycle).
//   - The owner dropping req mid-burst stalls the bus. The grant is kept; no re-arbitration
//     until last.
//   - bus_rdy=0 holds the beat. The requester must keep data/last stable while req=1 and rdy=0.
//   - Non-owner req/data/last are ignored. Only the owner's rdy can assert.
//   - Fairness: a requester that keeps req asserted wins within N arbitrations.
//   - rst asserted mid-burst: next cycle is the reset state. The burst is dropped silently and
//     no abort pulse is generated.
//   - X/Z on non-owner inputs must not reach any output.
//     The bus mux is a gated AND-OR on gnt, not an index select.
// CONFIGURATION
//   - Macro TLK_ARB_TIMEOUT_EN:
//     - Defined: beat_cnt (width $clog2(MAX_BEATS+1)) counts transfers in BUSY and clears in IDLE.
//     - Defined, and the transfer that makes beat_cnt reach MAX_BEATS has bus_last=0:
//       the arbiter releases exactly as if last were seen (gnt=0, ptr=owner, IDLE)
//       and abort pulses 1 cycle, in the cycle after that transfer.
//     - Defined, and a transfer with bus_last=1 at the limit is a normal end, with no abort.
//     - Undefined: no counter exists, abort is tied 0, and bursts are unbounded.
//     - The abort port exists in both builds so the interface is stable.
// STRUCTURE
//   - Package tlk_arb_pkg holds:
//     - typedef enum logic {IDLE, BUSY} arb_state_t;
//     - localparam defaults for N, DW and MAX_BEATS;
//     - function onehot2idx.
//   - Sub-module tlk_rr_pick (purely combinational; parameter N):
//     - inputs req[N] and ptr[$clog2(N)];
//     - outputs pick_oh[N] and any.
//   - Top level holds the FSM, ptr, gnt, beat_cnt and the AND-OR bus mux.
// TESTING
//   - Reset/idle: rst=1 for 2 cycles, then req=0
//     -> gnt=0, bus_vld=0, rdy=0, abort=0 on every cycle.
//   - Single burst: req[2]=1 with beats 0xA1,0xA2,0xA3 (last on 0xA3), bus_rdy=1
//     -> gnt=0100 from cycle 1; bus_data sequence A1,A2,A3; gnt=0 the cycle after A3.
//   - Round-robin: req=1111, each burst 1 beat (last=1), bus_rdy=1
//     -> owners in order 0,1,2,3,0, with an IDLE cycle between each.
//   - Backpressure/stall: owner 1, bus_rdy=0 for 3 cycles, then req[1]=0 for 2 cycles,
//     with req[0]=1 throughout
//     -> gnt stays 0010; no transfers; bus_data held at 0x5C; requester 0 waits.
//   - Reset mid-burst: rst=1 after 2 of 4 beats of requester 3
//     -> next cycle gnt=0; the next arbitration with req=1001 grants requester 0.
//   - TLK_ARB_TIMEOUT_EN, MAX_BEATS=4: requester 0 sends 6 beats, all last=0
//     -> 4 transfers; abort=1 for one cycle; then requester 1 (req[1]=1) is granted.

Source files
------------

// File: rtl/tlk_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// tlk_arb_pkg
//   Shared types, default parameters and helpers for the tlk bus arbiter.
//   Contents:
//     arb_state_t    two-state arbitration FSM encoding (IDLE / BUSY)
//     ARB_N          default number of requesters
//     ARB_DW         default beat width
//     ARB_MAX_BEATS  default burst length limit (timeout build only)
//     onehot2idx     binary index of a one-hot vector of up to 16 bits
// ----------------------------------------------------------------------------
package tlk_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int ARB_N         = 4;
  localparam int ARB_DW        = 8;
  localparam int ARB_MAX_BEATS = 16;

  // OR-reduction of set-bit indices; exact for a one-hot input, 0 for all-zero.
  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx |= 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tlk_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// tlk_bus_arbiter_if
//   Bundles the requester side and the shared downstream bus of the arbiter.
//   Parameters: N requesters, DW bits per beat.
//   Signals:
//     req[N], data[N][DW], last[N]   requester beats
//     rdy[N]                          per-requester accept
//     gnt[N]                          one-hot bus owner, 0 when idle
//     bus_vld, bus_data, bus_last     shared bus beat
//     bus_rdy                         downstream accept
//     abort                           one-cycle pulse when a burst is cut
//   Modports:
//     slave   the arbiter
//     master  requesters plus downstream sink (e.g. a testbench)
// ----------------------------------------------------------------------------
interface tlk_bus_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  logic [N-1:0]         req;
  logic [N-1:0][DW-1:0] data;
  logic [N-1:0]         last;
  logic [N-1:0]         rdy;
  logic [N-1:0]         gnt;
  logic                 bus_vld;
  logic [DW-1:0]        bus_data;
  logic                 bus_last;
  logic                 bus_rdy;
  logic                 abort;

  modport slave (
    input  req, data, last, bus_rdy,
    output rdy, gnt, bus_vld, bus_data, bus_last, abort
  );

  modport master (
    output req, data, last, bus_rdy,
    input  rdy, gnt, bus_vld, bus_data, bus_last, abort
  );
endinterface

// File: rtl/tlk_bus_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// tlk_rr_pick
//   Purely combinational round-robin selector. Returns the first set request
//   at or after index (ptr+1) mod N, wrapping around.
//   Ports:
//     req_i      N-bit request vector
//     ptr_i      index of the most recent owner
//     pick_oh_o  one-hot winner (all zero when no request)
//     any_o      at least one request is set
// ----------------------------------------------------------------------------
module tlk_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]                       req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                       pick_oh_o,
  output logic                               any_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick_oh_o = '0;
    found     = 1'b0;
    idx       = '0;
    // Scan N positions starting just past the previous owner.
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        pick_oh_o[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign any_o = |req_i;
endmodule

// File: rtl/tlk_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tlk_bus_arbiter
//   Round-robin arbiter giving N burst requesters exclusive use of one shared
//   byte-wide bus. A grant lasts a whole burst (until a beat with last=1).
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   tlk_bus_arbiter_if.slave (req/data/last/rdy/gnt/bus_*/abort)
//   Configuration:
//     TLK_ARB_TIMEOUT_EN  when defined, bursts are cut after MAX_BEATS
//                         transfers and abort pulses; otherwise abort is 0
//                         and bursts are unbounded.
// ----------------------------------------------------------------------------
module tlk_bus_arbiter
  import tlk_arb_pkg::*;
#(
  parameter int N         = ARB_N,
  parameter int DW        = ARB_DW,
  parameter int MAX_BEATS = ARB_MAX_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  tlk_bus_arbiter_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner;
  logic [N-1:0]  pick_oh;
  logic          pick_any;
  logic          mux_vld, mux_last;
  logic [DW-1:0] mux_data;
  logic          xfer;
  logic          at_limit;
  logic          release_burst;

  tlk_rr_pick #(.N(N)) u_pick (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .pick_oh_o (pick_oh),
    .any_o     (pick_any)
  );

  assign owner = PW'(onehot2idx(16'(gnt_q)));
  assign xfer  = mux_vld & bus.bus_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    release_burst = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          gnt_d   = pick_oh;
        end
      end
      BUSY: begin
        if (xfer && (mux_last || at_limit)) begin
          release_burst = 1'b1;
          state_d       = IDLE;
          gnt_d         = '0;
          ptr_d         = owner;
        end
      end
    endcase
  end

  // Output logic. The mux is an AND-OR gated by gnt so that X/Z on a
  // non-owner's inputs is masked by a 0 grant bit instead of propagating.
  always_comb begin
    mux_vld  = 1'b0;
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      mux_vld  = mux_vld  | (gnt_q[i] & bus.req[i]);
      mux_data = mux_data | ({DW{gnt_q[i]}} & bus.data[i]);
      mux_last = mux_last | (gnt_q[i] & bus.last[i]);
    end
    bus.gnt      = gnt_q;
    bus.bus_vld  = (state_q == BUSY) && mux_vld;
    bus.bus_data = mux_data;
    bus.bus_last = mux_last;
    bus.rdy      = (state_q == BUSY) ? (gnt_q & {N{bus.bus_rdy}}) : '0;
  end

`ifdef TLK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          abort_q, abort_d;

  // The transfer that would bring the count to MAX_BEATS ends the burst.
  assign at_limit = xfer && (beat_cnt_q == CW'(MAX_BEATS - 1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE || release_burst) begin
      beat_cnt_d = '0;
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
    // A burst that ends on its own last beat at the limit is not an abort.
    abort_d = release_burst && at_limit && !mux_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.abort = abort_q;
`else
  logic unused_cfg;

  assign at_limit   = 1'b0;
  assign bus.abort  = 1'b0;
  assign unused_cfg = ^MAX_BEATS;
`endif

endmodule

// File: tb/tb_tlk_bus_arbiter.sv
module tb_tlk_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
`ifdef TLK_ARB_TIMEOUT_EN
  localparam int MB = 4;
`else
  localparam int MB = 16;
`endif

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  beat_t exp_q[$];

  tlk_bus_arbiter_if #(.N(N), .DW(DW)) ifc ();

  tlk_bus_arbiter #(.N(N), .DW(DW), .MAX_BEATS(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst === 1'b0 && ifc.bus_vld === 1'b1 && ifc.bus_rdy === 1'b1) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got transfer gnt=%b data=%h last=%b, required none",
                 ifc.gnt, ifc.bus_data, ifc.bus_last);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if ({ifc.gnt, ifc.bus_data, ifc.bus_last} !== {e.gnt, e.data, e.last})
          $display("FAIL sb_beat: got gnt=%b data=%h last=%b, required gnt=%b data=%h last=%b",
                   ifc.gnt, ifc.bus_data, ifc.bus_last, e.gnt, e.data, e.last);
        else
          pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] g, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.gnt = g; b.data = d; b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ifc.req = '0; ifc.last = '0; ifc.data = '0; ifc.bus_rdy = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_cnt++;
      if ({ifc.gnt, ifc.bus_vld, ifc.rdy, ifc.abort} !== '0)
        $display("FAIL reset_outputs: got gnt=%b vld=%b rdy=%b abort=%b, required all 0",
                 ifc.gnt, ifc.bus_vld, ifc.rdy, ifc.abort);
      else pass_cnt++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cnt++;
      if ({ifc.gnt, ifc.bus_vld, ifc.rdy, ifc.abort} !== '0)
        $display("FAIL idle_outputs: got gnt=%b vld=%b rdy=%b abort=%b, required all 0",
                 ifc.gnt, ifc.bus_vld, ifc.rdy, ifc.abort);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] beats [3];
    beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
    for (int b = 0; b < 3; b++) push(4'b0100, beats[b], b == 2);
    ifc.bus_rdy = 1'b1;
    ifc.req = 4'b0100; ifc.data[2] = beats[0]; ifc.last = '0;
    #1;
    chk_cnt++;
    if (ifc.gnt !== 4'b0000 || ifc.rdy !== 4'b0000 || ifc.bus_vld !== 1'b0)
      $display("FAIL single_idle: got gnt=%b rdy=%b vld=%b, required 0000/0000/0",
               ifc.gnt, ifc.rdy, ifc.bus_vld);
    else pass_cnt++;
    tick();
    for (int b = 0; b < 3; b++) begin
      ifc.data[2] = beats[b];
      ifc.last[2] = (b == 2);
      #1;
      chk_cnt++;
      if (ifc.gnt !== 4'b0100 || ifc.bus_data !== beats[b] || ifc.rdy !== 4'b0100)
        $display("FAIL single_beat%0d: got gnt=%b data=%h rdy=%b, required 0100/%h/0100",
                 b, ifc.gnt, ifc.bus_data, ifc.rdy, beats[b]);
      else pass_cnt++;
      tick();
    end
    ifc.req = '0; ifc.last = '0;
    #1;
    chk_cnt++;
    if (ifc.gnt !== 4'b0000)
      $display("FAIL single_release: got gnt=%b, required 0000", ifc.gnt);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_owner [5];
    exp_owner[0] = 0; exp_owner[1] = 1; exp_owner[2] = 2; exp_owner[3] = 3; exp_owner[4] = 0;
    do_reset();
    ifc.bus_rdy = 1'b1;
    for (int i = 0; i < N; i++) ifc.data[i] = 8'h10 + 8'(i);
    ifc.last = 4'b1111;
    ifc.req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_cnt++;
      if (ifc.gnt !== 4'b0000)
        $display("FAIL rr_gap%0d: got gnt=%b, required 0000", k, ifc.gnt);
      else pass_cnt++;
      tick();
      push(4'(1 << exp_owner[k]), 8'h10 + 8'(exp_owner[k]), 1'b1);
      chk_cnt++;
      if (ifc.gnt !== 4'(1 << exp_owner[k]))
        $display("FAIL rr_owner%0d: got gnt=%b, required %b", k, ifc.gnt, 4'(1 << exp_owner[k]));
      else pass_cnt++;
      tick();
    end
    ifc.req = '0; ifc.last = '0;
    tick();
  endtask

  task automatic test_stall();
    // Previous owner was 0, so with req=0011 requester 1 wins.
    ifc.req = 4'b0011;
    ifc.data[1] = 8'h5C; ifc.last[1] = 1'b0;
    ifc.data[0] = 8'h77; ifc.last[0] = 1'b1;
    ifc.bus_rdy = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_cnt++;
      if (ifc.gnt !== 4'b0010 || ifc.bus_data !== 8'h5C || ifc.rdy !== 4'b0000 || ifc.bus_vld !== 1'b1)
        $display("FAIL stall_rdy%0d: got gnt=%b data=%h rdy=%b vld=%b, required 0010/5c/0000/1",
                 c, ifc.gnt, ifc.bus_data, ifc.rdy, ifc.bus_vld);
      else pass_cnt++;
      tick();
    end
    ifc.req[1] = 1'b0;
    ifc.bus_rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk_cnt++;
      if (ifc.gnt !== 4'b0010 || ifc.bus_vld !== 1'b0 || ifc.bus_data !== 8'h5C || ifc.rdy[0] !== 1'b0)
        $display("FAIL stall_req%0d: got gnt=%b vld=%b data=%h rdy=%b, required 0010/0/5c/rdy0=0",
                 c, ifc.gnt, ifc.bus_vld, ifc.bus_data, ifc.rdy);
      else pass_cnt++;
      tick();
    end
    ifc.req[1] = 1'b1; ifc.last[1] = 1'b1;
    push(4'b0010, 8'h5C, 1'b1);
    tick();
    ifc.req[1] = 1'b0;
    #1;
    chk_cnt++;
    if (ifc.gnt !== 4'b0000)
      $display("FAIL stall_release: got gnt=%b, required 0000", ifc.gnt);
    else pass_cnt++;
    tick();
    push(4'b0001, 8'h77, 1'b1);
    chk_cnt++;
    if (ifc.gnt !== 4'b0001)
      $display("FAIL stall_next_owner: got gnt=%b, required 0001", ifc.gnt);
    else pass_cnt++;
    tick();
    ifc.req = '0; ifc.last = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    // Previous owner was 0; req=1000 grants requester 3.
    ifc.bus_rdy = 1'b1;
    ifc.req = 4'b1000; ifc.last = '0; ifc.data[3] = 8'h31;
    push(4'b1000, 8'h31, 1'b0);
    push(4'b1000, 8'h32, 1'b0);
    tick();
    tick();
    ifc.data[3] = 8'h32;
    tick();
    ifc.data[3] = 8'h33;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.req = 4'b1001; ifc.data[0] = 8'h40; ifc.last[0] = 1'b1;
    #1;
    chk_cnt++;
    if (ifc.gnt !== 4'b0000 || ifc.abort !== 1'b0)
      $display("FAIL rstmid_gnt: got gnt=%b abort=%b, required 0000/0", ifc.gnt, ifc.abort);
    else pass_cnt++;
    tick();
    push(4'b0001, 8'h40, 1'b1);
    chk_cnt++;
    if (ifc.gnt !== 4'b0001)
      $display("FAIL rstmid_regrant: got gnt=%b, required 0001", ifc.gnt);
    else pass_cnt++;
    tick();
    ifc.req = '0; ifc.last = '0;
    tick();
  endtask

`ifdef TLK_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    ifc.bus_rdy = 1'b1;
    ifc.req = 4'b0011; ifc.last = 4'b0010;
    ifc.data[0] = 8'hB0; ifc.data[1] = 8'hC1;
    for (int b = 0; b < 4; b++) push(4'b0001, 8'hB0 + 8'(b), 1'b0);
    tick();
    for (int b = 0; b < 4; b++) begin
      ifc.data[0] = 8'hB0 + 8'(b);
      #1;
      chk_cnt++;
      if (ifc.gnt !== 4'b0001 || ifc.abort !== 1'b0)
        $display("FAIL tmo_beat%0d: got gnt=%b abort=%b, required 0001/0", b, ifc.gnt, ifc.abort);
      else pass_cnt++;
      tick();
    end
    ifc.data[0] = 8'hB4;
    #1;
    chk_cnt++;
    if (ifc.gnt !== 4'b0000 || ifc.abort !== 1'b1)
      $display("FAIL tmo_abort: got gnt=%b abort=%b, required 0000/1", ifc.gnt, ifc.abort);
    else pass_cnt++;
    tick();
    push(4'b0010, 8'hC1, 1'b1);
    chk_cnt++;
    if (ifc.gnt !== 4'b0010 || ifc.abort !== 1'b0)
      $display("FAIL tmo_next: got gnt=%b abort=%b, required 0010/0", ifc.gnt, ifc.abort);
    else pass_cnt++;
    tick();
    ifc.req = '0; ifc.last = '0;
    tick();
  endtask
`else
  task automatic test_long_burst();
    do_reset();
    ifc.bus_rdy = 1'b1;
    ifc.req = 4'b0001; ifc.last = '0;
    for (int b = 0; b < 20; b++) push(4'b0001, 8'hD0 + 8'(b), b == 19);
    tick();
    for (int b = 0; b < 20; b++) begin
      ifc.data[0] = 8'hD0 + 8'(b);
      ifc.last[0] = (b == 19);
      #1;
      if (b % 5 == 4) begin
        chk_cnt++;
        if (ifc.gnt !== 4'b0001 || ifc.abort !== 1'b0)
          $display("FAIL long_beat%0d: got gnt=%b abort=%b, required 0001/0", b, ifc.gnt, ifc.abort);
        else pass_cnt++;
      end
      tick();
    end
    ifc.req = '0; ifc.last = '0;
    #1;
    chk_cnt++;
    if (ifc.gnt !== 4'b0000 || ifc.abort !== 1'b0)
      $display("FAIL long_release: got gnt=%b abort=%b, required 0000/0", ifc.gnt, ifc.abort);
    else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    ifc.req = '0; ifc.data = '0; ifc.last = '0; ifc.bus_rdy = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_reset_mid_burst();
`ifdef TLK_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_burst();
`endif
    tick();
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain: got %0d beats outstanding, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
